// File: rtl/btn_debounce.sv
// btn_debounce: turns one raw mechanical push-button level into a clean
// debounced level (q) and a single-cycle press strobe (db_clk).
//
// Structure: two-flop synchronizer -> four-state debounce FSM with a
// stability counter. A level change is accepted only after the
// synchronized input has held the new level for DB_COUNT cycles beyond
// the cycle that first showed it.
//
// Legal configuration: DB_COUNT >= 1 and 2**CNT_W > DB_COUNT.
//
// Optional feature (compile-time macro BTN_DEBOUNCE_AUTO_REPEAT_EN):
// while the button stays accepted as pressed, db_clk re-fires after
// RPT_DELAY cycles and then every RPT_PERIOD cycles. With the macro
// undefined there is no repeat logic and RPT_DELAY/RPT_PERIOD are unused.

module btn_debounce #(
    parameter int unsigned DB_COUNT   = 262144,
    parameter int unsigned CNT_W      = 19,
    parameter int unsigned RPT_DELAY  = 12500000,
    parameter int unsigned RPT_PERIOD = 2500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic q,
    output logic db_clk
);

    typedef enum logic [1:0] {
        StZero,
        StWait1,
        StOne,
        StWait0
    } state_e;

    // Reload value for the stability counter on entry to a WAIT state.
    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(DB_COUNT - 1);

    logic             s1;
    logic             s2;
    state_e           state;
    logic [CNT_W-1:0] cnt;

`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
    localparam int unsigned RptMax = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int unsigned RcntW  = (RptMax > 1) ? $clog2(RptMax) : 1;

    localparam logic [RcntW-1:0] RptDelayLoad  = RcntW'(RPT_DELAY - 1);
    localparam logic [RcntW-1:0] RptPeriodLoad = RcntW'(RPT_PERIOD - 1);

    logic [RcntW-1:0] rcnt;
`else
    // Repeat timing parameters have no hardware in this build.
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{32'(RPT_DELAY), 32'(RPT_PERIOD)};
`endif

    // Two-flop synchronizer; the FSM only ever looks at s2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Debounce FSM with registered level, strobe and stability counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= StZero;
            cnt    <= '0;
            q      <= 1'b0;
            db_clk <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
            rcnt   <= '0;
`endif
        end else begin
            // Strobe defaults low so it can never stretch past one cycle.
            db_clk <= 1'b0;
            case (state)
                StZero: begin
                    q <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
                    rcnt <= '0;
`endif
                    if (s2) begin
                        state <= StWait1;
                        cnt   <= CntLoad;
                    end
                end

                StWait1: begin
                    q <= 1'b0;
                    if (!s2) begin
                        // Bounce: fall back without touching the outputs.
                        state <= StZero;
                    end else if (cnt == '0) begin
                        state  <= StOne;
                        q      <= 1'b1;
                        db_clk <= 1'b1;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
                        rcnt   <= RptDelayLoad;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                StOne: begin
                    q <= 1'b1;
                    if (!s2) begin
                        // Leaving ONE freezes the repeat counter.
                        state <= StWait0;
                        cnt   <= CntLoad;
                    end
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
                    else if (rcnt == '0) begin
                        db_clk <= 1'b1;
                        rcnt   <= RptPeriodLoad;
                    end else begin
                        rcnt <= rcnt - 1'b1;
                    end
`endif
                end

                StWait0: begin
                    q <= 1'b1;
                    if (s2) begin
                        // Release bounce: back to ONE, no new strobe.
                        state <= StOne;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
                        rcnt  <= RptDelayLoad;
`endif
                    end else if (cnt == '0) begin
                        state <= StZero;
                        q     <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state <= StZero;
                    q     <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // A strobe only ever occurs while the debounced level is high.
    a_db_implies_q: assert property (@(posedge clk) disable iff (reset) db_clk |-> q);

`ifndef BTN_DEBOUNCE_AUTO_REPEAT_EN
    // Without repeat, a strobe is one cycle wide and marks the 0->1 edge of q.
    a_db_single: assert property (@(posedge clk) disable iff (reset) db_clk |=> !db_clk);
    a_db_on_rise: assert property (@(posedge clk) disable iff (reset)
                                   db_clk |-> (q && !$past(q)));
`endif
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce (default build, DB_COUNT=4).
// Multi-cycle corner cases use per-cycle expectations; the table walks
// glitch, bounce and boundary-length sequences and checks the level and
// strobe count at the end of each segment.

module tb_btn_debounce;

    localparam int unsigned DbCount = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic raw   = 1'b0;
    logic q;
    logic db_clk;

    btn_debounce #(
        .DB_COUNT  (DbCount),
        .CNT_W     (3),
        .RPT_DELAY (5),
        .RPT_PERIOD(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .raw   (raw),
        .q     (q),
        .db_clk(db_clk)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic q;
        logic db;
    } cyc_exp_t;

    typedef struct {
        logic  q;
        int    nstrb;
    } seg_exp_t;

    typedef struct {
        logic  r;
        int    len;
        logic  eq;
        int    nstrb;
        string name;
    } seg_t;

    cyc_exp_t cyc_sb[$];
    seg_exp_t seg_sb[$];
    seg_t     segs[$];

    int   tests     = 0;
    int   fails     = 0;
    int   strobes   = 0;
    logic prev_db   = 1'b0;
    logic back2back = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive raw at the falling edge, sample #1 after the next rising edge.
    task automatic tick(input logic r);
        @(negedge clk);
        raw = r;
        @(posedge clk);
        #1;
        if (db_clk === 1'b1) begin
            strobes++;
            if (prev_db === 1'b1) back2back = 1'b1;
        end
        prev_db = db_clk;
    endtask

    task automatic cycle_chk(input logic r, input logic eq, input logic edb, input string name);
        cyc_exp_t e;
        cyc_sb.push_back('{q: eq, db: edb});
        tick(r);
        e = cyc_sb.pop_front();
        check({name, " q"}, 32'(q), 32'(e.q));
        check({name, " db_clk"}, 32'(db_clk), 32'(e.db));
    endtask

    initial begin
        int base;
        seg_exp_t se;

        // Segments start from a settled ZERO state.
        segs.push_back('{r: 1'b0, len: 4,  eq: 1'b0, nstrb: 0, name: "idle"});
        segs.push_back('{r: 1'b1, len: 4,  eq: 1'b0, nstrb: 0, name: "pulse_dbcount"});
        segs.push_back('{r: 1'b0, len: 10, eq: 1'b0, nstrb: 0, name: "pulse_dbcount_settle"});
        segs.push_back('{r: 1'b1, len: 5,  eq: 1'b0, nstrb: 0, name: "pulse_dbcount_p1"});
        segs.push_back('{r: 1'b0, len: 12, eq: 1'b0, nstrb: 1, name: "pulse_dbcount_p1_settle"});
        segs.push_back('{r: 1'b1, len: 2,  eq: 1'b0, nstrb: 0, name: "bounce_a"});
        segs.push_back('{r: 1'b0, len: 2,  eq: 1'b0, nstrb: 0, name: "bounce_b"});
        segs.push_back('{r: 1'b1, len: 2,  eq: 1'b0, nstrb: 0, name: "bounce_c"});
        segs.push_back('{r: 1'b0, len: 2,  eq: 1'b0, nstrb: 0, name: "bounce_d"});
        segs.push_back('{r: 1'b0, len: 10, eq: 1'b0, nstrb: 0, name: "bounce_settle"});
        segs.push_back('{r: 1'b1, len: 20, eq: 1'b1, nstrb: 1, name: "hold"});
        segs.push_back('{r: 1'b0, len: 3,  eq: 1'b1, nstrb: 0, name: "rel_glitch3"});
        segs.push_back('{r: 1'b1, len: 10, eq: 1'b1, nstrb: 0, name: "rel_glitch3_back"});
        segs.push_back('{r: 1'b0, len: 4,  eq: 1'b1, nstrb: 0, name: "rel_glitch4"});
        segs.push_back('{r: 1'b1, len: 10, eq: 1'b1, nstrb: 0, name: "rel_glitch4_back"});
        segs.push_back('{r: 1'b0, len: 12, eq: 1'b0, nstrb: 0, name: "release"});

        // Reset held across edges, even with the button pressed.
        reset = 1'b1;
        raw   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset q", 32'(q), 32'd0);
        check("reset db_clk", 32'(db_clk), 32'd0);
        raw = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) tick(1'b0);

        // Clean press: level and strobe exactly 2+DB_COUNT edges after sampling.
        base = strobes;
        for (int i = 0; i < 10; i++) cycle_chk(1'b1, i >= 6, i == 6, "press");
        check("press strobe count", 32'(strobes - base), 32'd1);

        // Symmetric release, no strobe.
        base = strobes;
        for (int i = 0; i < 10; i++) cycle_chk(1'b0, i < 6, 1'b0, "release");
        check("release strobe count", 32'(strobes - base), 32'd0);

        // Table of glitch / bounce / boundary segments.
        foreach (segs[k]) begin
            base = strobes;
            seg_sb.push_back('{q: segs[k].eq, nstrb: segs[k].nstrb});
            repeat (segs[k].len) tick(segs[k].r);
            se = seg_sb.pop_front();
            check({segs[k].name, " q"}, 32'(q), 32'(se.q));
            check({segs[k].name, " strobes"}, 32'(strobes - base), 32'(se.nstrb));
        end

        // Reset asynchronously mid-WAIT1 (counter at 2), then full latency again.
        for (int i = 0; i < 4; i++) cycle_chk(1'b1, 1'b0, 1'b0, "pre_reset_wait1");
        #1 reset = 1'b1;
        #1;
        check("async_reset_wait1 q", 32'(q), 32'd0);
        check("async_reset_wait1 db_clk", 32'(db_clk), 32'd0);
        #1 reset = 1'b0;
        prev_db = 1'b0;
        for (int i = 0; i < 9; i++) cycle_chk(1'b1, i >= 6, i == 6, "post_reset_wait1");

        repeat (12) tick(1'b0);
        check("idle_before_press2 q", 32'(q), 32'd0);

        // Reset between edges right after a strobe must clear q and db_clk at once.
        for (int i = 0; i < 7; i++) cycle_chk(1'b1, i >= 6, i == 6, "press2");
        #1 reset = 1'b1;
        #1;
        check("async_reset_one q", 32'(q), 32'd0);
        check("async_reset_one db_clk", 32'(db_clk), 32'd0);
        #1 reset = 1'b0;
        prev_db = 1'b0;
        for (int i = 0; i < 9; i++) cycle_chk(1'b1, i >= 6, i == 6, "post_reset_one");

        repeat (12) tick(1'b0);
        check("final q", 32'(q), 32'd0);
        check("no back-to-back strobe", 32'(back2back), 32'd0);
        check("total strobes", 32'(strobes), 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Debounces one raw mechanical push-button input into a clean level `q` and a single-cycle press strobe `db_clk`.
- Sits directly upstream of the button score counters and the seven-segment display path; one instance per button.
- Downstream counters increment once per `db_clk` pulse.
- Contains an input synchronizer, a four-state debounce FSM and a stability counter.

Parameters:
- DB_COUNT, 262144: consecutive stable synchronized cycles required before a level change is accepted. Legal range ≥ 1; 262144 gives ~10.5 ms at 25 MHz.
- CNT_W, 19: stability counter width. Must satisfy 2^CNT_W > DB_COUNT.
- RPT_DELAY, 12500000: cycles held in ONE before the first auto-repeat strobe. Used only with AUTO_REPEAT_EN.
- RPT_PERIOD, 2500000: cycles between subsequent auto-repeat strobes. Used only with AUTO_REPEAT_EN.

Ports:
- clk  input  1  system clock, single clock domain
- reset  input  1  asynchronous, active-high reset
- raw  input  1  asynchronous raw button level, 1 = pressed
- q  output  1  debounced level, registered
- db_clk  output  1  one-cycle press strobe, registered

Behaviour:
- Reset and clocking:
  - One clock `clk`. Reset `reset` is asynchronous and active-high.
  - All flops clear immediately on `reset`: s1=0, s2=0, state=ZERO, cnt=0, q=0, db_clk=0.
  - Reset asserted mid-operation (in any state) forces ZERO with no strobe, including on release.
- Synchronizer:
  - Two flops, s1 <= raw then s2 <= s1. The FSM sees only s2.
  - `raw` is never used combinationally.
- FSM states: ZERO, WAIT1, ONE, WAIT0.
  - ZERO: q=0. If s2=1 → WAIT1 with cnt <= DB_COUNT-1.
  - WAIT1: q=0.
    - s2=0 → ZERO (bounce rejected, no strobe).
    - s2=1 and cnt==0 → ONE, q <= 1, db_clk <= 1 for exactly one cycle.
    - Otherwise cnt <= cnt-1.
  - ONE: q=1. If s2=0 → WAIT0 with cnt <= DB_COUNT-1.
  - WAIT0: q=1.
    - s2=1 → ONE, with no new strobe.
    - s2=0 and cnt==0 → ZERO, q <= 0. No strobe on release.
    - Otherwise cnt <= cnt-1.
- Latency:
  - Let the first clock edge that samples raw=1 be edge e, with raw stable afterwards.
  - s2=1 after e+1; WAIT1 after e+2; q=1 and db_clk=1 after edge e+2+DB_COUNT.
  - db_clk deasserts after the next edge.
  - Release is symmetric: q=0 after edge e'+2+DB_COUNT.
- Strobe and counter rules:
  - db_clk pulses at most once per accepted press and is never high for two consecutive cycles.
  - db_clk is high only in the cycle in which q transitioned 0→1, except under AUTO_REPEAT_EN.
  - cnt is unsigned CNT_W bits. Decrement never underflows, because transitions occur at cnt==0.
  - Any glitch shorter than DB_COUNT synchronized cycles produces no change on q and no strobe.
- DB_COUNT=1 edge case: a level held for one extra cycle after WAIT entry is accepted.

Optional Feature:
- Macro: BTN_DEBOUNCE_AUTO_REPEAT_EN.
- Defined:
  - Adds a repeat counter `rcnt`, width ≥ clog2 of max(RPT_DELAY, RPT_PERIOD).
  - On entry to ONE, rcnt <= RPT_DELAY-1. While in ONE, rcnt decrements each cycle.
  - At rcnt==0, db_clk pulses for one cycle and rcnt <= RPT_PERIOD-1.
  - WAIT0 freezes rcnt. A return from WAIT0 to ONE reloads RPT_DELAY-1.
  - rcnt clears on reset and in ZERO.
- Undefined: no repeat logic exists; db_clk fires only on accepted presses.

Test Plan:
- Clean press, DB_COUNT=4: raw 0→1 sampled at edge 10, then held → q=1 and db_clk=1 after edge 16 only; db_clk=0 after edge 17; exactly one strobe.
- Bounce rejection, DB_COUNT=4: raw toggles 1,0,1,0 every 2 cycles, then returns to 0 → q stays 0 and db_clk never asserts.
- Press then release, DB_COUNT=4: press held 20 cycles, then raw=0 from edge 40 → q=0 after edge 46; no strobe on release; strobe count = 1.
- Release glitch, DB_COUNT=8: in ONE, raw=0 for 3 cycles then back to 1 → q stays 1 with no second strobe.
- Reset mid-WAIT1, DB_COUNT=4: assert reset asynchronously between edges while cnt=2 → q=0 and db_clk=0 immediately. After deassert with raw held 1, the full 2+DB_COUNT latency elapses before the strobe.
- With BTN_DEBOUNCE_AUTO_REPEAT_EN, DB_COUNT=2, RPT_DELAY=5, RPT_PERIOD=3: hold raw=1 for 20 cycles → strobes at q rise, +5, +8, +11, … cycles. No strobes after release.
